// File: rtl/rgb_to_color_pkg.sv
// ---------------------------------------------------------------------------
// rgb_to_color_pkg
//   Shared definitions for the RGB-to-palette colour matcher:
//     - width constants (RGB_W, IDX_W, DIST_W)
//     - search bounds and the initial "worse than anything" distance
//     - FSM state enum
//     - the fixed 16-entry TI99 palette and a forward lookup function
//   No ports (package).
// ---------------------------------------------------------------------------
package rgb_to_color_pkg;

  localparam int RGB_W  = 12;
  localparam int IDX_W  = 4;
  localparam int DIST_W = 6;

  // Index 0 is transparent and is never searched, so the scan runs 1..15.
  localparam logic [IDX_W-1:0]  FIRST_IDX = 4'd1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = 4'd15;

  // Larger than the maximum real distance (45), so entry 1 always wins
  // against the initial best.
  localparam logic [DIST_W-1:0] DIST_INIT = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // TI99 palette, 4 bits per channel, R=[11:8] G=[7:4] B=[3:0].
  localparam logic [RGB_W-1:0] PALETTE [0:15] = '{
    12'h000, 12'h000, 12'h2C3, 12'h5D6,
    12'h54F, 12'h76F, 12'hD54, 12'h4EF,
    12'hF54, 12'hF76, 12'hDC3, 12'hED6,
    12'h2B2, 12'hC5C, 12'hCCC, 12'hFFF
  };

  // Forward lookup: palette index -> RGB value.
  function automatic logic [RGB_W-1:0] palette_rgb(input logic [IDX_W-1:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/rgb_to_color_color_distance.sv
// ---------------------------------------------------------------------------
// color_distance
//   Purely combinational Manhattan distance between two 12-bit RGB colours:
//   |dR| + |dG| + |dB| on unsigned 4-bit channels. Maximum is 45, which
//   fits in 6 bits without overflow.
//   Ports:
//     a_i    [11:0] first colour
//     b_i    [11:0] second colour
//     dist_o [5:0]  distance
// ---------------------------------------------------------------------------
module color_distance
  import rgb_to_color_pkg::*;
(
  input  logic [RGB_W-1:0]  a_i,
  input  logic [RGB_W-1:0]  b_i,
  output logic [DIST_W-1:0] dist_o
);

  function automatic logic [3:0] abs_diff(input logic [3:0] x, input logic [3:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  logic [3:0] dr;
  logic [3:0] dg;
  logic [3:0] db;

  assign dr = abs_diff(a_i[11:8], b_i[11:8]);
  assign dg = abs_diff(a_i[7:4],  b_i[7:4]);
  assign db = abs_diff(a_i[3:0],  b_i[3:0]);

  // Zero-extend each channel before summing so the carry is kept.
  assign dist_o = {2'b00, dr} + {2'b00, dg} + {2'b00, db};

endmodule

// File: rtl/rgb_to_color.sv
// ---------------------------------------------------------------------------
// rgb_to_color
//   Maps a 12-bit RGB request to the nearest non-transparent entry of the
//   TI99 palette by scanning indices 1..15, one per clock. The scan stops
//   early on an exact match. Ties keep the lowest index.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both 1. The producer holds data stable while valid is high and
//   ready is low; ready never depends combinationally on valid.
//
//   Ports:
//     clk         rising-edge clock
//     reset_n     asynchronous active-low reset
//     rgb_in      [11:0] requested colour
//     in_valid    rgb_in valid
//     in_ready    block can accept (only in IDLE, decoded from state)
//     color_out   [3:0] nearest palette index (1..15)
//     dist_out    [5:0] distance to that entry
//     exact_out   dist_out == 0
//     out_valid   result valid (DONE state)
//     out_ready   consumer accepts result
//     dbg_state_o [1:0] current FSM state (state_e encoding)
// ---------------------------------------------------------------------------
module rgb_to_color
  import rgb_to_color_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [RGB_W-1:0]  rgb_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [IDX_W-1:0]  color_out,
  output logic [DIST_W-1:0] dist_out,
  output logic              exact_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        dbg_state_o
);

  state_e              state_q,     state_d;
  logic [IDX_W-1:0]    idx_q,       idx_d;
  logic [IDX_W-1:0]    best_idx_q,  best_idx_d;
  logic [DIST_W-1:0]   best_dist_q, best_dist_d;
  logic [RGB_W-1:0]    rgb_q,       rgb_d;
  logic [IDX_W-1:0]    color_q,     color_d;
  logic [DIST_W-1:0]   dist_q,      dist_d;
  logic                exact_q,     exact_d;
  logic                out_valid_q, out_valid_d;

  logic [DIST_W-1:0]   cur_dist;
  logic                better;
  logic [IDX_W-1:0]    win_idx;
  logic [DIST_W-1:0]   win_dist;

  // Distance from the latched request to the entry under evaluation.
  color_distance u_dist (
    .a_i    (rgb_q),
    .b_i    (palette_rgb(idx_q)),
    .dist_o (cur_dist)
  );

  // Strictly-smaller compare keeps the earliest (lowest) index on ties.
  assign better   = (cur_dist < best_dist_q);
  assign win_idx  = better ? idx_q    : best_idx_q;
  assign win_dist = better ? cur_dist : best_dist_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      best_idx_q  <= '0;
      best_dist_q <= '0;
      rgb_q       <= '0;
      color_q     <= '0;
      dist_q      <= '0;
      exact_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      best_idx_q  <= best_idx_d;
      best_dist_q <= best_dist_d;
      rgb_q       <= rgb_d;
      color_q     <= color_d;
      dist_q      <= dist_d;
      exact_q     <= exact_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    best_idx_d  = best_idx_q;
    best_dist_d = best_dist_q;
    rgb_d       = rgb_q;
    color_d     = color_q;
    dist_d      = dist_q;
    exact_d     = exact_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          rgb_d       = rgb_in;
          idx_d       = FIRST_IDX;
          best_idx_d  = FIRST_IDX;
          best_dist_d = DIST_INIT;
          state_d     = ST_SEARCH;
        end
      end

      ST_SEARCH: begin
        best_idx_d  = win_idx;
        best_dist_d = win_dist;
        // An exact match cannot be beaten, so stop scanning there.
        if ((cur_dist == '0) || (idx_q == LAST_IDX)) begin
          color_d     = win_idx;
          dist_d      = win_dist;
          exact_d     = (win_dist == '0);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      ST_DONE: begin
        // Result registers hold until the consumer takes them; IDLE
        // follows, so a new request cannot share the handshake cycle.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign color_out   = color_q;
  assign dist_out    = dist_q;
  assign exact_out   = exact_q;
  assign out_valid   = out_valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rgb_to_color.sv
// ---------------------------------------------------------------------------
// tb_rgb_to_color
//   Directed testbench for rgb_to_color. Expected palette indices,
//   distances and latencies are hand-computed from the TI99 palette.
// ---------------------------------------------------------------------------
module tb_rgb_to_color;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic        clk;
  logic        reset_n;
  logic [11:0] rgb_in;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  color_out;
  logic [5:0]  dist_out;
  logic        exact_out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  dbg_state;

  int vectors;
  int miscompares;

  rgb_to_color dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rgb_in      (rgb_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .color_out   (color_out),
    .dist_out    (dist_out),
    .exact_out   (exact_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Wait (bounded) until the block is idle; call at posedge+1.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_idle_timeout: in_ready=%b want 1", name, in_ready);
    end
  endtask

  // Count edges after the accepting edge until out_valid (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  // Present one request and take the accepting edge.
  task automatic launch(input logic [11:0] rgb);
    rgb_in   = rgb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scribble on rgb_in: the latched request must be used.
    rgb_in   = 12'($urandom_range(0, 4095));
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rgb_in    = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || color_out !== 4'd0 || dist_out !== 6'd0 || exact_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: ov=%b c=%0d d=%0d e=%b want 0/0/0/0",
               out_valid, color_out, dist_out, exact_out);
    end
    vectors++;
    if (dbg_state !== S_IDLE || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: state=%0d in_ready=%b want 0/1", dbg_state, in_ready);
    end
    // First request is accepted on the first edge after release.
    @(negedge clk);
    reset_n  = 1'b1;
    rgb_in   = 12'h000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (dbg_state !== S_SEARCH) begin
      miscompares++;
      $display("FAIL reset_first_accept: state=%0d want %0d", dbg_state, S_SEARCH);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_search(input string name, input logic [11:0] rgb,
                             input logic [3:0] exp_c, input logic [5:0] exp_d,
                             input logic exp_e, input int exp_lat);
    int lat;
    out_ready = 1'b1;
    wait_idle(name);
    launch(rgb);
    wait_result(lat);
    vectors++;
    if (lat !== exp_lat || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d (ov=%b) want %0d", name, lat, out_valid, exp_lat);
    end
    vectors++;
    if (color_out !== exp_c || dist_out !== exp_d || exact_out !== exp_e) begin
      miscompares++;
      $display("FAIL %s_result: c=%0d d=%0d e=%b want c=%0d d=%0d e=%b",
               name, color_out, dist_out, exact_out, exp_c, exp_d, exp_e);
    end
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_in_ready_done: got %b want 0", name, in_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_release: ov=%b ir=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    wait_idle("bp");
    launch(12'hD54);
    wait_result(lat);
    vectors++;
    if (lat !== 6) begin
      miscompares++;
      $display("FAIL bp_latency: got %0d want 6", lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || color_out !== 4'd6 || dist_out !== 6'd0 ||
          exact_out !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: ov=%b c=%0d d=%0d e=%b ir=%b want 1/6/0/1/0",
                 i, out_valid, color_out, dist_out, exact_out, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (dbg_state !== S_IDLE || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: state=%0d ov=%b ir=%b want 0/0/1", dbg_state, out_valid, in_ready);
    end
  endtask

  // in_valid held high across a handshake: no acceptance in that cycle.
  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    wait_idle("b2b");
    rgb_in   = 12'h000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    wait_result(lat);
    vectors++;
    if (lat !== 1 || color_out !== 4'd1) begin
      miscompares++;
      $display("FAIL b2b_first: lat=%0d c=%0d want 1/1", lat, color_out);
    end
    @(posedge clk); #1;   // result handshake edge
    vectors++;
    if (dbg_state !== S_IDLE || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_no_accept_on_handshake: state=%0d ir=%b want 0/1", dbg_state, in_ready);
    end
    @(posedge clk); #1;   // new accept
    in_valid = 1'b0;
    vectors++;
    if (dbg_state !== S_SEARCH) begin
      miscompares++;
      $display("FAIL b2b_second_accept: state=%0d want %0d", dbg_state, S_SEARCH);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_search();
    int lat;
    out_ready = 1'b1;
    wait_idle("rst_mid");
    launch(12'hFFF);          // idx=1 after accept
    repeat (6) begin
      @(posedge clk); #1;     // idx reaches 7
    end
    vectors++;
    if (dbg_state !== S_SEARCH || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_pre: state=%0d ov=%b want 1/0", dbg_state, out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || color_out !== 4'd0 || dist_out !== 6'd0 ||
        exact_out !== 1'b0 || dbg_state !== S_IDLE) begin
      miscompares++;
      $display("FAIL rst_mid_async: ov=%b c=%0d d=%0d e=%b st=%0d want all 0",
               out_valid, color_out, dist_out, exact_out, dbg_state);
    end
    rgb_in   = 12'h5D6;
    in_valid = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rgb_in   = 12'($urandom_range(0, 4095));
    wait_result(lat);
    vectors++;
    if (lat !== 3 || color_out !== 4'd3 || dist_out !== 6'd0 || exact_out !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_after: lat=%0d c=%0d d=%0d e=%b want 3/3/0/1",
               lat, color_out, dist_out, exact_out);
    end
    @(posedge clk); #1;
  endtask

  // Reset while a result is pending discards it.
  task automatic test_reset_pending();
    int lat;
    out_ready = 1'b0;
    wait_idle("rst_pend");
    launch(12'h54F);
    wait_result(lat);
    vectors++;
    if (lat !== 4 || color_out !== 4'd4 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pend_result: lat=%0d c=%0d ov=%b want 4/4/1", lat, color_out, out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || color_out !== 4'd0 || dbg_state !== S_IDLE) begin
      miscompares++;
      $display("FAIL rst_pend_discard: ov=%b c=%0d st=%0d want 0/0/0", out_valid, color_out, dbg_state);
    end
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_search("black",     12'h000, 4'd1,  6'd0, 1'b1, 1);
    test_search("white",     12'hFFF, 4'd15, 6'd0, 1'b1, 15);
    test_search("near_miss", 12'hF55, 4'd8,  6'd1, 1'b0, 15);
    test_search("tie",       12'h2C2, 4'd2,  6'd1, 1'b0, 15);
    test_search("grey",      12'h777, 4'd3,  6'd9, 1'b0, 15);
    test_search("magenta",   12'hC5C, 4'd13, 6'd0, 1'b1, 13);
    test_backpressure();
    test_back_to_back();
    test_reset_mid_search();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
